// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: drives register-file reads, forwards from EX/MEM/WB, stalls on
// load-use hazards and registers the resolved operands into a valid/ready ID/EX register.
module operand_fetch_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned RA_W     = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RA_W-1:0] in_rs1,
  input  logic [RA_W-1:0] in_rs2,
  input  logic [RA_W-1:0] in_rd,
  input  logic            in_rd_we,
  input  logic            in_is_load,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  output logic [RA_W-1:0] rf_read_reg1,
  output logic [RA_W-1:0] rf_read_reg2,
  input  logic [XLEN-1:0] rf_read_data1,
  input  logic [XLEN-1:0] rf_read_data2,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_rd_we,
  input  logic            ex_is_load,
  input  logic [XLEN-1:0] ex_result,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_rd_we,
  input  logic [XLEN-1:0] mem_result,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_we,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_op_a,
  output logic [XLEN-1:0] out_op_b,
  output logic [RA_W-1:0] out_rd,
  output logic            out_rd_we,
  output logic            out_is_load,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     stall_count
);

  logic            hazard;
  logic            transfer;
  logic [XLEN-1:0] op_a, op_b;

  logic            out_valid_d, out_valid_q;
  logic [XLEN-1:0] out_op_a_d, out_op_a_q, out_op_b_d, out_op_b_q;
  logic [RA_W-1:0] out_rd_d, out_rd_q;
  logic            out_rd_we_d, out_rd_we_q, out_is_load_d, out_is_load_q;
  logic [XLEN-1:0] out_imm_d, out_imm_q, out_pc_d, out_pc_q;
  logic [31:0]     stall_count_d, stall_count_q;

  assign rf_read_reg1 = in_rs1;
  assign rf_read_reg2 = in_rs2;

  // WB must be forwarded: the register-file write only lands at the clock edge.
  function automatic logic [XLEN-1:0] resolve(input logic [RA_W-1:0] rs,
                                              input logic [XLEN-1:0] rf_data,
                                              input logic [RA_W-1:0] e_rd,
                                              input logic            e_we,
                                              input logic            e_ld,
                                              input logic [XLEN-1:0] e_res,
                                              input logic [RA_W-1:0] m_rd,
                                              input logic            m_we,
                                              input logic [XLEN-1:0] m_res,
                                              input logic [RA_W-1:0] w_rd,
                                              input logic            w_we,
                                              input logic [XLEN-1:0] w_dat);
    logic [XLEN-1:0] res;
    if (ZERO_REG != 0 && rs == '0)        res = '0;
    else if (e_we && e_rd == rs && !e_ld) res = e_res;
    else if (m_we && m_rd == rs)          res = m_res;
    else if (w_we && w_rd == rs)          res = w_dat;
    else                                  res = rf_data;
    return res;
  endfunction

  always_comb begin
    op_a = resolve(in_rs1, rf_read_data1, ex_rd, ex_rd_we, ex_is_load, ex_result,
                   mem_rd, mem_rd_we, mem_result, wb_rd, wb_we, wb_data);
    op_b = resolve(in_rs2, rf_read_data2, ex_rd, ex_rd_we, ex_is_load, ex_result,
                   mem_rd, mem_rd_we, mem_result, wb_rd, wb_we, wb_data);
  end

  // Both sources are checked even if the instruction does not use them.
  assign hazard   = in_valid && ex_is_load && ex_rd_we && (ex_rd != '0) &&
                    ((ex_rd == in_rs1) || (ex_rd == in_rs2));
  assign in_ready = !hazard && (!out_valid_q || out_ready);
  assign transfer = in_valid && in_ready;

  always_comb begin
    out_valid_d   = out_valid_q;
    out_op_a_d    = out_op_a_q;
    out_op_b_d    = out_op_b_q;
    out_rd_d      = out_rd_q;
    out_rd_we_d   = out_rd_we_q;
    out_is_load_d = out_is_load_q;
    out_imm_d     = out_imm_q;
    out_pc_d      = out_pc_q;
    stall_count_d = stall_count_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (transfer) begin
      out_valid_d   = 1'b1;
      out_op_a_d    = op_a;
      out_op_b_d    = op_b;
      out_rd_d      = in_rd;
      out_rd_we_d   = in_rd_we;
      out_is_load_d = in_is_load;
      out_imm_d     = in_imm;
      out_pc_d      = in_pc;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (hazard && !flush && stall_count_q != 32'hFFFF_FFFF) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_op_a_q    <= '0;
      out_op_b_q    <= '0;
      out_rd_q      <= '0;
      out_rd_we_q   <= 1'b0;
      out_is_load_q <= 1'b0;
      out_imm_q     <= '0;
      out_pc_q      <= '0;
      stall_count_q <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_op_a_q    <= out_op_a_d;
      out_op_b_q    <= out_op_b_d;
      out_rd_q      <= out_rd_d;
      out_rd_we_q   <= out_rd_we_d;
      out_is_load_q <= out_is_load_d;
      out_imm_q     <= out_imm_d;
      out_pc_q      <= out_pc_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_op_a    = out_op_a_q;
  assign out_op_b    = out_op_b_q;
  assign out_rd      = out_rd_q;
  assign out_rd_we   = out_rd_we_q;
  assign out_is_load = out_is_load_q;
  assign out_imm     = out_imm_q;
  assign out_pc      = out_pc_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios plus randomized traffic checked against
// a transaction-level model of the ID/EX register.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rd_we, in_is_load;
  logic [31:0] in_imm, in_pc;
  logic [4:0]  rf_read_reg1, rf_read_reg2;
  logic [31:0] rf_read_data1, rf_read_data2;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic        ex_rd_we, ex_is_load, mem_rd_we, wb_we;
  logic [31:0] ex_result, mem_result, wb_data;
  logic        flush, out_valid, out_ready;
  logic [31:0] out_op_a, out_op_b, out_imm, out_pc, stall_count;
  logic [4:0]  out_rd;
  logic        out_rd_we, out_is_load;

  int checks = 0;
  int errors = 0;

  // Expected ID/EX register contents
  logic        m_valid;
  logic [31:0] m_a, m_b, m_imm, m_pc, m_stall;
  logic [4:0]  m_rd;
  logic        m_we, m_ld;

  always #5 clk = ~clk;

  operand_fetch_stage #(.XLEN(32), .RA_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .in_is_load(in_is_load), .in_imm(in_imm), .in_pc(in_pc),
    .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load), .ex_result(ex_result),
    .mem_rd(mem_rd), .mem_rd_we(mem_rd_we), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .out_is_load(out_is_load), .out_imm(out_imm), .out_pc(out_pc),
    .stall_count(stall_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Newest producer wins; a load in EX has no result yet.
  function automatic logic [31:0] ref_operand(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 5'd0) return 32'd0;
    if (ex_rd_we && ex_rd == rs && !ex_is_load) return ex_result;
    if (mem_rd_we && mem_rd == rs) return mem_result;
    if (wb_we && wb_rd == rs) return wb_data;
    return rf;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_a = 0; m_b = 0; m_imm = 0; m_pc = 0; m_stall = 0;
    m_rd = 0; m_we = 0; m_ld = 0;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_we = 0; in_is_load = 0;
    in_imm = 0; in_pc = 0; rf_read_data1 = 0; rf_read_data2 = 0;
    ex_rd = 0; ex_rd_we = 0; ex_is_load = 0; ex_result = 0;
    mem_rd = 0; mem_rd_we = 0; mem_result = 0;
    wb_rd = 0; wb_we = 0; wb_data = 0; flush = 0; out_ready = 1;
  endtask

  task automatic compare_outputs(input bit all_fields);
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("stall_count", stall_count, m_stall);
    if (m_valid || all_fields) begin
      check("out_op_a", out_op_a, m_a);
      check("out_op_b", out_op_b, m_b);
      check("out_rd", {27'd0, out_rd}, {27'd0, m_rd});
      check("out_rd_we", {31'd0, out_rd_we}, {31'd0, m_we});
      check("out_is_load", {31'd0, out_is_load}, {31'd0, m_ld});
      check("out_imm", out_imm, m_imm);
      check("out_pc", out_pc, m_pc);
    end
  endtask

  // Inputs are already applied; checks combinational outputs, clocks once, checks registers.
  task automatic step();
    bit hz, rdy, n_valid;
    logic [31:0] n_a, n_b, n_imm, n_pc, n_stall;
    logic [4:0] n_rd;
    logic n_we, n_ld;
    #1;
    hz  = in_valid && ex_is_load && ex_rd_we && ex_rd != 0 &&
          (ex_rd == in_rs1 || ex_rd == in_rs2);
    rdy = !hz && (!m_valid || out_ready);
    check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    check("rf_read_reg1", {27'd0, rf_read_reg1}, {27'd0, in_rs1});
    check("rf_read_reg2", {27'd0, rf_read_reg2}, {27'd0, in_rs2});
    n_valid = m_valid; n_a = m_a; n_b = m_b; n_imm = m_imm; n_pc = m_pc;
    n_rd = m_rd; n_we = m_we; n_ld = m_ld; n_stall = m_stall;
    if (flush) n_valid = 0;
    else if (in_valid && rdy) begin
      n_valid = 1;
      n_a = ref_operand(in_rs1, rf_read_data1);
      n_b = ref_operand(in_rs2, rf_read_data2);
      n_rd = in_rd; n_we = in_rd_we; n_ld = in_is_load; n_imm = in_imm; n_pc = in_pc;
    end else if (m_valid && out_ready) n_valid = 0;
    if (hz && !flush && m_stall != 32'hFFFF_FFFF) n_stall = m_stall + 1;
    @(posedge clk);
    #1;
    m_valid = n_valid; m_a = n_a; m_b = n_b; m_imm = n_imm; m_pc = n_pc;
    m_rd = n_rd; m_we = n_we; m_ld = n_ld; m_stall = n_stall;
    compare_outputs(0);
  endtask

  task automatic random_inputs();
    in_valid      = ($urandom_range(0, 3) != 0);
    in_rs1        = 5'($urandom_range(0, 7));
    in_rs2        = 5'($urandom_range(0, 7));
    in_rd         = 5'($urandom_range(0, 31));
    in_rd_we      = 1'($urandom_range(0, 1));
    in_is_load    = 1'($urandom_range(0, 1));
    in_imm        = $urandom;
    in_pc         = $urandom;
    rf_read_data1 = $urandom;
    rf_read_data2 = $urandom;
    ex_rd         = 5'($urandom_range(0, 7));
    ex_rd_we      = 1'($urandom_range(0, 1));
    ex_is_load    = ($urandom_range(0, 3) == 0);
    ex_result     = $urandom;
    mem_rd        = 5'($urandom_range(0, 7));
    mem_rd_we     = 1'($urandom_range(0, 1));
    mem_result    = $urandom;
    wb_rd         = 5'($urandom_range(0, 7));
    wb_we         = 1'($urandom_range(0, 1));
    wb_data       = $urandom;
    flush         = ($urandom_range(0, 9) == 0);
    out_ready     = ($urandom_range(0, 9) < 7);
  endtask

  initial begin
    logic [31:0] held_b;
    // Reset with a valid instruction presented
    rst_n = 0;
    idle_inputs();
    in_valid = 1;
    model_reset();
    #12;
    compare_outputs(1);
    @(posedge clk);
    #1;
    rst_n = 1;
    in_rs1 = 3; rf_read_data1 = 32'h11; in_rs2 = 4; rf_read_data2 = 32'h22;
    step();
    check("first_op_a", out_op_a, 32'h11);

    // Forwarding priority EX > MEM > WB
    in_rs1 = 5; rf_read_data1 = 32'hF0;
    ex_rd = 5; ex_rd_we = 1; ex_result = 32'hA;
    mem_rd = 5; mem_rd_we = 1; mem_result = 32'hB;
    wb_rd = 5; wb_we = 1; wb_data = 32'hC;
    step();
    check("fwd_ex", out_op_a, 32'hA);
    ex_rd_we = 0;
    step();
    check("fwd_mem", out_op_a, 32'hB);
    mem_rd_we = 0;
    step();
    check("fwd_wb", out_op_a, 32'hC);

    // Load-use stall on rs2
    idle_inputs();
    in_valid = 1; in_rs1 = 1; in_rs2 = 7;
    ex_is_load = 1; ex_rd_we = 1; ex_rd = 7;
    step();
    check("lu_valid", {31'd0, out_valid}, 32'd0);
    check("lu_stall", stall_count, 32'd1);
    ex_is_load = 0; ex_rd_we = 0; ex_rd = 0;
    mem_rd = 7; mem_rd_we = 1; mem_result = 32'h55;
    step();
    check("lu_op_b", out_op_b, 32'h55);

    // Backpressure for three cycles
    held_b = out_op_b;
    out_ready = 0; mem_rd_we = 0;
    for (int i = 0; i < 3; i++) begin
      in_rs2 = 5'(i + 2); rf_read_data2 = $urandom; in_pc = $urandom;
      step();
      check("bp_hold_b", out_op_b, held_b);
    end
    out_ready = 1; in_rs2 = 9; rf_read_data2 = 32'h99;
    step();
    check("bp_release", out_op_b, 32'h99);

    // Flush wins over a concurrent transfer
    flush = 1;
    step();
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    flush = 0;
    in_rs1 = 0; rf_read_data1 = 32'hDEAD; wb_rd = 0; wb_we = 1; wb_data = 32'h1234;
    step();
    check("zero_reg", out_op_a, 32'd0);

    for (int i = 0; i < 400; i++) begin
      random_inputs();
      step();
    end

    // Async reset mid-cycle while holding a valid instruction
    idle_inputs();
    in_valid = 1; in_rs1 = 2; rf_read_data1 = 32'h77;
    step();
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #3;
    rst_n = 0;
    #1;
    model_reset();
    compare_outputs(1);
    #20;
    rst_n = 1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
Decode-to-execute pipeline stage that sits directly upstream of the register file's read ports and downstream of decode.
- Drives the register-file read addresses from the decoded instruction.
- Resolves operands by forwarding from the EX, MEM and WB stages.
- Detects load-use hazards and inserts bubbles.
- Registers the resolved operands into a valid/ready-handshaked ID/EX output register feeding the ALU.

Parameters:
XLEN, 32, data/operand width (matches register-file word width)
RA_W, 5, register address width (32 architectural registers)
ZERO_REG, 1, 1 = register 0 reads as zero regardless of register-file contents

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  decoded instruction present
in_ready  output  1  stage accepts instruction this cycle
in_rs1  input  RA_W  source register 1
in_rs2  input  RA_W  source register 2
in_rd  input  RA_W  destination register
in_rd_we  input  1  instruction writes rd
in_is_load  input  1  instruction is a load
in_imm  input  XLEN  immediate, passed through
in_pc  input  XLEN  PC, passed through
rf_read_reg1  output  RA_W  register-file read address 1 (= in_rs1)
rf_read_reg2  output  RA_W  register-file read address 2 (= in_rs2)
rf_read_data1  input  XLEN  register-file read data 1 (combinational)
rf_read_data2  input  XLEN  register-file read data 2 (combinational)
ex_rd, ex_rd_we, ex_is_load, ex_result  input  RA_W/1/1/XLEN  instruction currently in EX
mem_rd, mem_rd_we, mem_result  input  RA_W/1/XLEN  instruction in MEM
wb_rd, wb_we, wb_data  input  RA_W/1/XLEN  write-back port (same signals drive the register file's write port)
flush  input  1  squash (branch taken)
out_valid  output  1  ID/EX register holds valid instruction
out_ready  input  1  EX accepts
out_op_a, out_op_b  output  XLEN  resolved operands
out_rd, out_rd_we, out_is_load, out_imm, out_pc  output  as inputs  registered pass-through
stall_count  output  32  saturating count of load-use stall cycles

Behaviour:
- Reset (async, rst_n=0): all outputs zero, including out_valid, all out_* fields and stall_count. Reset release is used synchronously. Reset mid-transfer drops the instruction.
- rf_read_reg1/2 are combinational copies of in_rs1/in_rs2.
- Operand resolution for each source rs, in priority order:
  - rs==0 with ZERO_REG=1 → 0.
  - ex_rd_we && ex_rd==rs && !ex_is_load → ex_result.
  - mem_rd_we && mem_rd==rs → mem_result.
  - wb_we && wb_rd==rs → wb_data. This is required because the register-file write lands only at the clock edge.
  - Otherwise rf_read_dataN.
- Load-use hazard: hazard = in_valid && ex_is_load && ex_rd_we && ex_rd!=0 && (ex_rd==in_rs1 || ex_rd==in_rs2). Both sources are checked regardless of use.
- in_ready = !hazard && (!out_valid || out_ready). Purely combinational; does not depend on in_valid except through hazard.
- Transfer when in_valid && in_ready: latency 1 cycle. Next cycle out_valid=1 and the out_* fields hold the resolved operands/fields.
- If out_valid && out_ready and no new transfer: out_valid←0 (bubble). Data fields may hold stale values.
- If out_valid && !out_ready: all out_* fields hold stable (no change while valid and not accepted).
- Flush: next cycle out_valid←0, and any same-cycle input transfer is discarded. Flush overrides a simultaneous transfer and hold. Flush does not clear stall_count.
- stall_count increments each cycle hazard=1 (and !flush). Saturates at 0xFFFF_FFFF.
- Forwarding values are sampled in the transfer cycle only. Operands are not re-resolved while held in the output register.

Test Plan:
1. Reset with in_valid=1 → all outputs 0. First edge after rst_n=1 with rs1=3, rf_read_data1=0x11 → out_op_a=0x11, out_valid=1.
2. Forward priority: rs1=5, ex_rd=5 (non-load, ex_result=0xA), mem_rd=5 (0xB), wb_rd=5 (0xC) → out_op_a=0xA. Drop ex_rd_we → 0xB. Drop mem_rd_we → 0xC.
3. Load-use: ex_is_load=1, ex_rd=7, in_rs2=7 → in_ready=0 for that cycle, out_valid=0 after EX consumes, stall_count=1. Next cycle (mem_rd=7, mem_result=0x55) → accepted, out_op_b=0x55.
4. Backpressure: out_ready=0 for 3 cycles with out_valid=1 → in_ready=0 and out_* unchanged. Release → next instruction captured in 1 cycle.
5. Flush concurrent with transfer → next cycle out_valid=0. rs1=0 with rf_read_data1=0xDEAD and wb_rd=0 → out_op_a=0.
6. Async reset asserted mid-cycle with out_valid=1 → out_valid falls immediately without a clock edge.
